// File: rtl/cpu_lsu_pkg.sv
// rtl/cpu_lsu_pkg.sv - shared encodings and defaults for the load/store unit
package cpu_lsu_pkg;

    // funct3 access size/sign encodings (stores reuse B/H/W)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM state encodings
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] DONE = 3'd2;
    localparam logic [2:0] ERR  = 3'd3;
    localparam logic [2:0] TOUT = 3'd4;

    // Internal access-size codes
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int DEFAULT_TIMEOUT = 16;

    // Size depends only on the low funct3 bits; undefined codes fall to word
    function automatic logic [1:0] accessSize(input logic [1:0] f3Lo);
        case (f3Lo)
            2'b00:   accessSize = SZ_B;
            2'b01:   accessSize = SZ_H;
            default: accessSize = SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/cpu_lsu_align.sv
// rtl/cpu_lsu_align.sv - byte-lane steering, extension and misalign detection
module cpu_lsu_align
    import cpu_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      reqF3Lo,
    input  logic [1:0]      reqOffset,
    input  logic [XLEN-1:0] reqWdata,
    output logic [3:0]      reqWstrb,
    output logic [XLEN-1:0] laneWdata,
    output logic            misaligned,
    input  logic [2:0]      ldFunct3,
    input  logic [1:0]      ldOffset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] loadExt
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    // Store side: strobes, lane-replicated data and alignment check of the live request
    always_comb begin
        reqWstrb   = 4'b1111;
        laneWdata  = reqWdata;
        misaligned = 1'b0;
        case (accessSize(reqF3Lo))
            SZ_B: begin
                reqWstrb  = 4'b0001 << reqOffset;
                laneWdata = {4{reqWdata[7:0]}};
            end
            SZ_H: begin
                reqWstrb   = 4'b0011 << reqOffset;
                laneWdata  = {2{reqWdata[15:0]}};
                misaligned = reqOffset[0];
            end
            default: begin
                misaligned = |reqOffset;
            end
        endcase
    end

    // Load side: pick the addressed lane of the bus word and extend it
    always_comb begin
        byteLane = rdata[{ldOffset, 3'b000} +: 8];
        halfLane = ldOffset[1] ? rdata[31:16] : rdata[15:0];
        loadExt  = rdata;
        case (accessSize(ldFunct3[1:0]))
            SZ_B:    loadExt = ldFunct3[2] ? {{(XLEN-8){1'b0}}, byteLane}
                                           : {{(XLEN-8){byteLane[7]}}, byteLane};
            SZ_H:    loadExt = ldFunct3[2] ? {{(XLEN-16){1'b0}}, halfLane}
                                           : {{(XLEN-16){halfLane[15]}}, halfLane};
            default: loadExt = rdata;
        endcase
    end

endmodule

// File: rtl/cpu_lsu.sv
// rtl/cpu_lsu.sv - load/store unit: request FSM, bus handshake and timeout
module cpu_lsu
    import cpu_lsu_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            req_valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] load_data,
    output logic            misalign_err,
    output logic            bus_err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_wstrb,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata
);

    localparam int CW = $clog2(TIMEOUT);

    logic [2:0]      state;
    logic [CW-1:0]   tmoCount;
    logic [2:0]      f3Reg;
    logic [1:0]      offReg;
    logic            weReg;
    logic [XLEN-1:0] addrReg;
    logic [XLEN-1:0] wdataReg;
    logic [3:0]      strbReg;
    logic [XLEN-1:0] loadReg;

    logic            accept;
    logic            isStore;
    logic            misaligned;
    logic [3:0]      reqWstrb;
    logic [XLEN-1:0] laneWdata;
    logic [XLEN-1:0] loadExt;

    // A write wins when both controls are high
    assign accept  = (state == IDLE) && req_valid && (mem_read || mem_write);
    assign isStore = mem_write;

    cpu_lsu_align #(.XLEN(XLEN)) u_align (
        .reqF3Lo    (funct3[1:0]),
        .reqOffset  (addr[1:0]),
        .reqWdata   (wdata),
        .reqWstrb   (reqWstrb),
        .laneWdata  (laneWdata),
        .misaligned (misaligned),
        .ldFunct3   (f3Reg),
        .ldOffset   (offReg),
        .rdata      (bus_rdata),
        .loadExt    (loadExt)
    );

    // Request FSM: latch the access on accept, wait for ack or timeout, report for one cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            tmoCount <= '0;
            f3Reg    <= '0;
            offReg   <= '0;
            weReg    <= 1'b0;
            addrReg  <= '0;
            wdataReg <= '0;
            strbReg  <= '0;
            loadReg  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        tmoCount <= '0;
                        if (misaligned) begin
                            state <= ERR;
                        end else begin
                            state    <= REQ;
                            f3Reg    <= funct3;
                            offReg   <= addr[1:0];
                            weReg    <= isStore;
                            addrReg  <= {addr[XLEN-1:2], 2'b00};
                            wdataReg <= laneWdata;
                            strbReg  <= isStore ? reqWstrb : 4'b0000;
                        end
                    end
                end
                REQ: begin
                    if (bus_ack) begin
                        state <= DONE;
                        if (!weReg) begin
                            loadReg <= loadExt;
                        end
                    end else if (tmoCount == CW'(TIMEOUT - 1)) begin
                        state <= TOUT;
                    end else begin
                        tmoCount <= tmoCount + 1'b1;
                    end
                end
                DONE, ERR, TOUT: state <= IDLE;
                default:         state <= IDLE;
            endcase
        end
    end

    assign bus_req      = (state == REQ);
    assign bus_we       = weReg & bus_req;
    assign bus_addr     = addrReg;
    assign bus_wstrb    = bus_req ? strbReg : 4'b0000;
    assign bus_wdata    = wdataReg;
    assign stall        = accept || (state == REQ);
    assign done         = (state == DONE) || (state == ERR) || (state == TOUT);
    assign misalign_err = (state == ERR);
    assign bus_err      = (state == TOUT);
    assign load_data    = loadReg;

endmodule

// File: tb/tb_cpu_lsu.sv
// tb/tb_cpu_lsu.sv - scoreboard bench for the load/store unit
module tb_cpu_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        req_valid = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic        done;
    logic [31:0] load_data;
    logic        misalign_err;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;

    typedef struct packed {
        logic        mis;
        logic        berr;
        logic [31:0] ld;
    } expT;

    expT         expQ[$];
    expT         monE;
    int          checks = 0;
    int          fails = 0;
    logic [31:0] expLoad = '0;

    always #5 clk = ~clk;

    cpu_lsu #(.TIMEOUT(16), .XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .req_valid    (req_valid),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .done         (done),
        .load_data    (load_data),
        .misalign_err (misalign_err),
        .bus_err      (bus_err),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wstrb    (bus_wstrb),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    // Completion monitor: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (done) begin
            checks++;
            if (expQ.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: done pulsed with no access outstanding at %0t", $time);
            end else begin
                monE = expQ.pop_front();
                if ({misalign_err, bus_err, load_data} !== {monE.mis, monE.berr, monE.ld}) begin
                    fails++;
                    $display("FAIL completion: got mis=%0b berr=%0b ld=%h, want mis=%0b berr=%0b ld=%h",
                             misalign_err, bus_err, load_data, monE.mis, monE.berr, monE.ld);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rd);
        int          sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = int'(off);
        b  = rd[sh*8 +: 8];
        h  = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  modelLoad = {{24{b[7]}}, b};
            3'b100:  modelLoad = {24'h0, b};
            3'b001:  modelLoad = {{16{h[15]}}, h};
            3'b101:  modelLoad = {16'h0, h};
            default: modelLoad = rd;
        endcase
    endfunction

    function automatic logic modelMis(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'b000, 3'b100: modelMis = 1'b0;
            3'b001, 3'b101: modelMis = a[0];
            default:        modelMis = (a[1:0] != 2'b00);
        endcase
    endfunction

    // Issue one access, act as the bus, and return in the cycle done pulses
    task automatic doAccess(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input int ackAt, input logic [31:0] rd,
                            input logic [3:0] expStrb, input logic [31:0] expWd,
                            output int reqCycles);
        logic mis;
        logic accepted;
        logic berr;
        expT  e;
        reqCycles = 0;
        mis       = modelMis(f3, a);
        req_valid = 1'b1;
        mem_write = wr;
        mem_read  = !wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        accepted  = 1'b0;
        for (int w = 0; w < 4 && !accepted; w++) begin
            @(negedge clk);
            if (done) begin
                checks++;
                if (stall !== 1'b0) begin
                    fails++;
                    $display("FAIL stall_in_done: got %0b want 0", stall);
                end
                @(posedge clk); #1;
            end else begin
                accepted = 1'b1;
            end
        end
        checks++;
        if (!accepted || stall !== 1'b1) begin
            fails++;
            $display("FAIL accept_stall: got %0b want 1", stall);
        end
        berr  = !mis && (ackAt < 0 || ackAt >= 16);
        if (!wr && !mis && !berr) expLoad = modelLoad(f3, a[1:0], rd);
        e.mis  = mis;
        e.berr = berr;
        e.ld   = expLoad;
        expQ.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (mis) begin
            checks++;
            if (done !== 1'b1 || misalign_err !== 1'b1 || bus_req !== 1'b0) begin
                fails++;
                $display("FAIL misalign_cycle: got done=%0b mis=%0b req=%0b want 1 1 0",
                         done, misalign_err, bus_req);
            end
            return;
        end
        for (int i = 0; i < 40; i++) begin
            if (!bus_req) break;
            reqCycles++;
            if (i == 0) begin
                checks++;
                if (bus_addr !== {a[31:2], 2'b00} || bus_we !== wr || bus_wstrb !== expStrb ||
                    (wr && bus_wdata !== expWd)) begin
                    fails++;
                    $display("FAIL bus_fields: got addr=%h we=%0b strb=%b wd=%h want addr=%h we=%0b strb=%b wd=%h",
                             bus_addr, bus_we, bus_wstrb, bus_wdata, {a[31:2], 2'b00}, wr, expStrb, expWd);
                end
            end
            if (i == ackAt) begin
                bus_ack   = 1'b1;
                bus_rdata = rd;
            end
            @(posedge clk); #1;
            bus_ack   = 1'b0;
            bus_rdata = $urandom;
        end
        checks++;
        if (done !== 1'b1 || stall !== 1'b0 || bus_req !== 1'b0) begin
            fails++;
            $display("FAIL done_cycle: got done=%0b stall=%0b req=%0b want 1 0 0", done, stall, bus_req);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({stall, done, misalign_err, bus_err, bus_req, bus_we, bus_wstrb, load_data, bus_addr} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got stall=%0b done=%0b req=%0b strb=%b ld=%h addr=%h want all 0",
                     stall, done, bus_req, bus_wstrb, load_data, bus_addr);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_store();
        int rc;
        doAccess(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 1, '0, 4'b1000, 32'hABAB_ABAB, rc);
        checks++;
        if (rc != 2) begin
            fails++;
            $display("FAIL sb_req_cycles: got %0d want 2", rc);
        end
        doAccess(1'b1, 3'b001, 32'h0000_1002, 32'h5555_1234, 0, '0, 4'b1100, 32'h1234_1234, rc);
        doAccess(1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 2, '0, 4'b1111, 32'hDEAD_BEEF, rc);
    endtask

    task automatic test_load_ext();
        int rc;
        doAccess(1'b0, 3'b000, 32'h0000_2001, '0, 0, 32'h0000_8000, 4'b0000, '0, rc);
        checks++;
        if (rc != 1) begin
            fails++;
            $display("FAIL lb_latency: got %0d req cycles want 1", rc);
        end
        doAccess(1'b0, 3'b100, 32'h0000_2001, '0, 0, 32'h0000_8000, 4'b0000, '0, rc);
        doAccess(1'b0, 3'b101, 32'h0000_2002, '0, 1, 32'hBEEF_0000, 4'b0000, '0, rc);
        doAccess(1'b0, 3'b001, 32'h0000_2002, '0, 0, 32'hBEEF_0000, 4'b0000, '0, rc);
        doAccess(1'b0, 3'b000, 32'h0000_2003, '0, 0, 32'h7F00_00FF, 4'b0000, '0, rc);
        doAccess(1'b0, 3'b011, 32'h0000_2000, '0, 0, 32'h1234_5678, 4'b0000, '0, rc);
    endtask

    task automatic test_misalign();
        int rc;
        doAccess(1'b0, 3'b010, 32'h0000_3002, '0, 0, 32'hFFFF_FFFF, 4'b0000, '0, rc);
        doAccess(1'b1, 3'b001, 32'h0000_3001, 32'h0000_AAAA, 0, '0, 4'b0000, '0, rc);
        doAccess(1'b0, 3'b101, 32'h0000_3003, '0, 0, 32'hFFFF_FFFF, 4'b0000, '0, rc);
    endtask

    task automatic test_timeout();
        int rc;
        doAccess(1'b0, 3'b010, 32'h0000_5000, '0, -1, 32'h1111_1111, 4'b0000, '0, rc);
        checks++;
        if (rc != 16) begin
            fails++;
            $display("FAIL timeout_req_cycles: got %0d want 16", rc);
        end
        doAccess(1'b0, 3'b010, 32'h0000_5004, '0, 15, 32'h600D_F00D, 4'b0000, '0, rc);
        checks++;
        if (rc != 16) begin
            fails++;
            $display("FAIL late_ack_req_cycles: got %0d want 16", rc);
        end
    endtask

    task automatic test_reset_in_req();
        int rc;
        @(posedge clk); #1;
        req_valid = 1'b1;
        mem_read  = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h0000_0040;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_read  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus_req !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset_req: got %0b want 1", bus_req);
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || load_data !== '0) begin
            fails++;
            $display("FAIL reset_in_req: got req=%0b stall=%0b done=%0b ld=%h want 0 0 0 0",
                     bus_req, stall, done, load_data);
        end
        expLoad = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        doAccess(1'b0, 3'b010, 32'h0000_0044, '0, 0, 32'h0BAD_F00D, 4'b0000, '0, rc);
    endtask

    task automatic test_back_to_back();
        int          rc;
        logic [31:0] memWord;
        memWord = 32'hCAFE_F00D;
        doAccess(1'b1, 3'b010, 32'h0000_0010, memWord, 0, '0, 4'b1111, memWord, rc);
        doAccess(1'b0, 3'b010, 32'h0000_0010, '0, 0, memWord, 4'b0000, '0, rc);
        checks++;
        if (rc != 1) begin
            fails++;
            $display("FAIL b2b_req_cycles: got %0d want 1", rc);
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load_ext();
        test_misalign();
        test_timeout();
        test_reset_in_req();
        test_back_to_back();
        @(negedge clk);
        @(posedge clk); #1;
        checks++;
        if (expQ.size() != 0) begin
            fails++;
            $display("FAIL leftover_expectations: got %0d pending want 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
